// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order instruction fetch with credit-limited memory requests,
// a registered instruction FIFO feeding decode, and redirect flush that drains
// stale in-flight responses.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d;
  logic [AW-1:0]   tag_wr_q, tag_wr_d;
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] tag_q       [DEPTH];

  logic          req_hs;
  logic          rsp_live;
  logic          redir;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_upd;
  logic          unused_pc_lsbs;

  // Low redirect address bits are forced to zero, so they are never consumed.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Request credit: only issue while buffered plus outstanding stays below DEPTH.
  always_comb begin
    imem_req_valid = (state_q == FETCH) &&
                     ((32'(inflight_q) + 32'(fifo_cnt_q)) < DEPTH);
  end

  assign imem_req_addr = pc_q;
  assign inst_valid    = (fifo_cnt_q != '0);
  assign inst_data     = fifo_data_q[rd_ptr_q];
  assign inst_pc       = fifo_pc_q[rd_ptr_q];
  assign opcode        = inst_data[6:0];

  // Next-state logic: fetch bookkeeping, drain counting, redirect override.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    push       = 1'b0;
    pop        = inst_valid & inst_ready;
    req_hs     = imem_req_valid & imem_req_ready;
    rsp_live   = (state_q == FETCH) && imem_rsp_valid && (inflight_q != '0);
    redir      = redirect_valid && (state_q != BOOT);
    inflight_upd = inflight_q + CW'(req_hs) - CW'(rsp_live);

    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (req_hs) begin
          pc_d     = pc_q + XLEN'(4);
          tag_wr_d = tag_wr_q + AW'(1);
        end
        if (rsp_live) begin
          push     = 1'b1;
          tag_rd_d = tag_rd_q + AW'(1);
        end
        inflight_d = inflight_upd;
      end
      DRAIN: begin
        if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase

    if (redir) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      push       = 1'b0;
      pop        = 1'b0;
      inflight_d = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      if (state_q == FETCH) drop_d = inflight_upd;
      state_d    = (drop_d != '0) ? DRAIN : FETCH;
    end

    fifo_cnt_d = redir ? '0 : (fifo_cnt_q + CW'(push) - CW'(pop));
    rd_ptr_d   = redir ? '0 : (rd_ptr_q + AW'(pop));
    wr_ptr_d   = redir ? '0 : (wr_ptr_q + AW'(push));
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Instruction FIFO storage and per-request address tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data_q[AW'(i)] <= '0;
        fifo_pc_q[AW'(i)]   <= '0;
        tag_q[AW'(i)]       <= '0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= imem_rsp_data;
        fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      end
      if (req_hs) tag_q[tag_wr_q] <= pc_q;
    end
  end

  // A response arriving while the FIFO is full and not draining is a protocol error.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !((state_q == FETCH) && imem_rsp_valid && (fifo_cnt_q == CW'(DEPTH)) && !pop && !redir));

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (req_hs && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if ((state_q != BOOT) && !inst_valid && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redir && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage; produces the instruction stream whose opcode field feeds the main control decoder.
- Issues in-order word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Branch redirect flushes the buffer and discards stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries and maximum in-flight requests (power of two, >=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid, in request order, any latency >=1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch taken / PC redirect.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0).
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  XLEN  instruction word.
- inst_pc  out  XLEN  address of inst_data.
- opcode  out  7  inst_data[6:0], direct to control decoder.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, state=BOOT; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- FSM states:
  - BOOT: one cycle with no requests, then FETCH.
  - FETCH: normal operation.
  - DRAIN: waits for stale responses; no requests issued.
- FETCH:
  - imem_req_valid=1 iff inflight + fifo_count < DEPTH.
  - imem_req_addr=pc.
  - On a req handshake: pc += 4, inflight += 1.
- Response in FETCH:
  - Pushes {pc_tag, data} into the FIFO; inflight -= 1.
  - pc_tag comes from a per-request address queue.
  - Credit rule guarantees the FIFO never overflows. A response with FIFO full is a protocol error; flag it with an assertion only.
- Decode interface:
  - inst_valid = FIFO not empty; inst_data/inst_pc/opcode show the FIFO head.
  - Pop on inst_valid & inst_ready.
  - Latency: request accepted in cycle N with response in N+1 gives inst_valid in N+2 (registered FIFO).
- Redirect (highest priority, any state except BOOT):
  - Same edge: pc=redirect_pc, FIFO flushed, inst_valid=0 next cycle.
  - A pop and a response arriving in the same cycle are discarded.
  - A request handshake in the same cycle is counted as stale.
  - drop_cnt = inflight after this cycle's updates. If drop_cnt>0, state=DRAIN, else FETCH.
- DRAIN:
  - Each response decrements drop_cnt and is discarded.
  - At 0, go to FETCH; the first request issues the following cycle at the redirected pc.
  - A further redirect in DRAIN updates pc and keeps the current drop_cnt.
- PC wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- Simultaneous push and pop with FIFO full or empty is legal; count is unchanged or handled as pass-through via the registered stage.
- rst asserted mid-operation overrides everything; any responses after reset are ignored until the first new request. The memory is reset alongside.

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined, adds three outputs:
  - perf_fetch_cnt (32): count of request handshakes.
  - perf_stall_cnt (32): cycles with inst_valid=0 in FETCH/DRAIN.
  - perf_flush_cnt (32): count of redirects.
- All three reset to 0 and saturate at 0xFFFF_FFFF.
- When undefined, these ports and counters are absent; the core behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, memory always ready, 1-cycle latency, decode always ready -> first request after BOOT at 0x100; inst_pc sequence 0x100, 0x104, 0x108; opcode matches data[6:0] (e.g. 0x00A00093 gives 0x13).
- Decode held not-ready for 10 cycles -> exactly DEPTH=2 requests issued, then imem_req_valid=0; on release, 0x100 and 0x104 are delivered in order with no loss.
- 2 requests in flight with 3-cycle latency, redirect to 0x200 -> both stale responses dropped; DRAIN lasts until the second response; next request addr=0x200; no pre-redirect inst_valid afterwards.
- Redirect in the same cycle as a response and pop -> response discarded, FIFO empty next cycle, the following inst_pc is 0x200.
- pc=0xFFFF_FFFC -> next request addr=0x0000_0000.
- rst asserted mid-stream with FIFO full -> next cycle: inst_valid=0, imem_req_valid=0; after BOOT, fetch restarts at RESET_PC. With IFETCH_PERF_EN defined, all counters read 0 after reset.
